// File: rtl/div_iter_radix2.sv
// div_iter_radix2: sequential radix-2 restoring divider, signed/unsigned 32-bit, valid/ready + cancel.
// Optional DIV_EARLY_TERM_EN: finish at accept when |x| < |y|. Rev 1.0
`default_nettype none

module div_iter_radix2 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             div_cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [WIDTH-1:0]     s_q, s_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]     x_mag, y_mag;
  logic [WIDTH:0]       top;
  logic                 ge;
  logic [WIDTH-1:0]     diff;
  logic [2*WIDTH-1:0]   step;
  logic [WIDTH-1:0]     quo, rmd;

  assign x_mag = (div_signed && x[WIDTH-1]) ? -x : x;
  assign y_mag = (div_signed && y[WIDTH-1]) ? -y : y;

  // Shifted upper half needs WIDTH+1 bits because it can reach 2*|y|-1.
  assign top  = rem_q[2*WIDTH-1:WIDTH-1];
  assign ge   = top >= {1'b0, dvs_q};
  assign diff = top[WIDTH-1:0] - dvs_q;
  assign step = ge ? {diff, rem_q[WIDTH-2:0], 1'b1} : {rem_q[2*WIDTH-2:0], 1'b0};
  assign quo  = step[WIDTH-1:0];
  assign rmd  = step[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    s_d     = s_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    if (div_cancel) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_valid) begin
            if (y == '0) begin
              s_d     = '1;
              r_d     = x;
              dbz_d   = 1'b1;
              state_d = DONE;
`ifdef DIV_EARLY_TERM_EN
            end else if (x_mag < y_mag) begin
              s_d     = '0;
              r_d     = x;
              dbz_d   = 1'b0;
              state_d = DONE;
`endif
            end else begin
              rem_d   = {{WIDTH{1'b0}}, x_mag};
              dvs_d   = y_mag;
              cnt_d   = '0;
              qneg_d  = div_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
              rneg_d  = div_signed && x[WIDTH-1];
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == {CNT_W{1'b1}}) begin
            s_d     = qneg_q ? -quo : quo;
            r_d     = rneg_q ? -rmd : rmd;
            dbz_d   = 1'b0;
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      s_q     <= s_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign div_ready   = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign s           = s_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_div_iter_radix2.sv
// tb_div_iter_radix2: directed + random scoreboard bench for div_iter_radix2.
`default_nettype none

module tb_div_iter_radix2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        div_valid = 1'b0;
  logic        div_ready;
  logic        div_signed = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        div_cancel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] s;
  logic [31:0] r;
  logic        div_by_zero;

  div_iter_radix2 #(.WIDTH(32), .CNT_W(5)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .x          (x),
    .y          (y),
    .div_cancel (div_cancel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .s          (s),
    .r          (r),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic [31:0] r;
    logic [31:0] dbz;
    logic [31:0] lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sg);
    return (sg && v[31]) ? -v : v;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sg);
    exp_t e;
    e.dbz = 32'd0;
    e.lat = 32'd32;
    if (b == 32'd0) begin
      e.s = 32'hFFFF_FFFF; e.r = a; e.dbz = 32'd1; e.lat = 32'd0;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.s = 32'h8000_0000; e.r = 32'd0;
    end else if (sg) begin
      e.s = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end else begin
      e.s = a / b;
      e.r = a % b;
    end
`ifdef DIV_EARLY_TERM_EN
    if (b != 32'd0 && mag(a, sg) < mag(b, sg)) e.lat = 32'd0;
`endif
    return e;
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sg, input bit push);
    int g = 0;
    while (!div_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    check("ready_before_accept", {31'd0, div_ready}, 32'd1);
    x = a; y = b; div_signed = sg; div_valid = 1'b1;
    if (push) sb.push_back(model(a, b, sg));
    @(posedge clk); #1;
    div_valid = 1'b0;
    x = $urandom; y = $urandom; div_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic get_result(input string tag, input int hold);
    exp_t        e;
    int          n = 0;
    logic [31:0] s0, r0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_lat"}, n, e.lat);
      check({tag, "_s"}, s, e.s);
      check({tag, "_r"}, r, e.r);
      check({tag, "_dbz"}, {31'd0, div_by_zero}, e.dbz);
    end
    s0 = s; r0 = r;
    for (int i = 0; i < hold; i++) begin
      div_valid = 1'b1; x = 32'd50; y = 32'd5; div_signed = 1'b0;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_ready"}, {31'd0, div_ready}, 32'd0);
      check({tag, "_hold_s"}, s, s0);
      check({tag, "_hold_r"}, r, r0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    div_valid = 1'b0;
    check({tag, "_release_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_release_ready"}, {31'd0, div_ready}, 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_hi;
    logic [31:0] ra, rb;
    logic        rs;

    #12;
    check("rst_ready", {31'd0, div_ready}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_s", s, 32'd0);
    check("rst_r", r, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    start_op(32'd100, 32'd7, 1'b0, 1'b1);
    get_result("u100_7", 0);
    check("u100_7_known_s", sb.size(), 32'd0);

    start_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    get_result("sneg7_2", 0);
    start_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    get_result("uneg7_2", 0);

    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    get_result("s_ovf", 0);
    start_op(32'h1234_5678, 32'd0, 1'b1, 1'b1);
    get_result("zdiv_s", 0);
    start_op(32'h8765_4321, 32'd0, 1'b0, 1'b1);
    get_result("zdiv_u", 0);
    start_op(32'd0, 32'd17, 1'b1, 1'b1);
    get_result("x_zero", 0);
    start_op(32'd5, 32'd9, 1'b0, 1'b1);
    get_result("early_5_9", 0);
    start_op(32'hFFFF_FFFB, 32'd9, 1'b1, 1'b1);
    get_result("early_neg5_9", 0);

    start_op(32'hDEAD_BEEF, 32'd1234, 1'b0, 1'b1);
    get_result("backpressure", 5);

    start_op(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    div_cancel = 1'b1;
    @(posedge clk); #1;
    div_cancel = 1'b0;
    check("cancel_ready", {31'd0, div_ready}, 32'd1);
    check("cancel_valid", {31'd0, out_valid}, 32'd0);
    cnt_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt_hi++;
    end
    check("cancel_no_result", cnt_hi, 32'd0);
    start_op(32'd9, 32'd3, 1'b0, 1'b1);
    get_result("after_cancel_9_3", 0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      if (i == 3) rb = -rb;
      rs = 1'(i % 3 != 0);
      start_op(ra, rb, rs, 1'b1);
      get_result($sformatf("rand%0d", i), 0);
    end

    start_op(32'd777, 32'd5, 1'b1, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    #3 resetn = 1'b0;
    #1;
    check("arst_ready", {31'd0, div_ready}, 32'd1);
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_s", s, 32'd0);
    check("arst_r", r, 32'd0);
    check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    start_op(32'd45, 32'd6, 1'b0, 1'b1);
    get_result("after_reset_45_6", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
